wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage of the three-stage RV32I pipeline; sits directly downstream of execute.
//  Consumes execute's wb_* bundle, issues data-memory stores, aligns and extends load data,
//  and drives the register-file write port.
//  Stalls upstream while a load or store handshake is outstanding. Flags misaligned or illegal accesses.
// PARAMETERS
//  XLEN      32  datapath width
//  REGSEL_W  5   register-select width (32 registers)
// PORTS
//  clk          in   1     clock, rising edge
//  resetb       in   1     asynchronous, active-low reset
//  wb_valid     in   1     execute presents a valid instruction
//  wb_result    in   32    ALU/link/LUI/AUIPC result
//  wb_alu2reg   in   1     write wb_result to rd
//  wb_mem2reg   in   1     load: write aligned dmem_rdata to rd
//  wb_memwr     in   1     store
//  wb_dst_sel   in   5     rd index
//  wb_raddr     in   2     load byte offset (addr[1:0])
//  wb_aluop     in   3     load funct3: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU
//  wb_waddr     in   32    store byte address
//  wb_wstrb     in   4     store byte strobes, pre-shifted by execute
//  wb_wdata     in   32    store data, pre-shifted by execute
//  dmem_rdata   in   32    load data, word aligned
//  dmem_rvalid  in   1     load data valid
//  dmem_wvalid  in   1     store accepted by memory
//  dmem_wready  out  1     store request
//  dmem_waddr   out  32    store address
//  dmem_wdata   out  32    store data
//  dmem_wstrb   out  4     store strobes
//  rf_we        out  1     register write enable; never asserted for rd = x0
//  rf_waddr     out  5     register write index
//  rf_wdata     out  32    register write data; also used as the forwarding source
//  wb_stall     out  1     hold execute/IF_ID this cycle
//  wb_exception out  1     one-cycle pulse on illegal access
//  rdcycle      out  64    cycle counter (see CONFIGURATION)
//  rdinstret    out  64    retired-instruction counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE, captured registers 0. All outputs 0: rf_we, dmem_wready, wb_stall,
//    wb_exception, counters.
//  - FSM states: IDLE, LD_WAIT, ST_WAIT.
//  - IDLE, wb_valid:
//    - alu2reg: rf_we = (rd != 0) combinationally in the same cycle; retire.
//    - mem2reg with dmem_rvalid=1: write aligned data the same cycle; retire.
//    - mem2reg with dmem_rvalid=0: capture rd/aluop/raddr, go to LD_WAIT, assert wb_stall.
//    - memwr: dmem_wready=1 with wb_waddr/wdata/wstrb this cycle. wvalid=1: retire.
//      wvalid=0: capture request, go to ST_WAIT, assert wb_stall.
//  - LD_WAIT: wb_stall=1 and inputs ignored. On dmem_rvalid: write from captured fields,
//    go to IDLE, wb_stall=0 that cycle.
//  - ST_WAIT: dmem_wready=1 and the captured request is held stable. On dmem_wvalid: go to IDLE.
//  - Load extract: LB/LBU take byte wb_raddr; LH/LHU take half wb_raddr[1]; LW takes the full word.
//    LB/LH sign-extend; LBU/LHU zero-extend.
//  - Illegal access (checked in IDLE with wb_valid): LH/LHU with raddr[0]=1; LW with raddr!=0;
//    funct3 3/6/7 on a load; mem2reg and memwr both set.
//    Response: wb_exception=1 for one cycle, no rf write, no store, no retire, stay IDLE.
//  - alu2reg together with mem2reg: mem2reg wins.
//  - A store to an out-of-range address is still issued; range checking is done by the memory side.
//  - Reset asserted in LD_WAIT or ST_WAIT: pending access dropped, dmem_wready falls immediately
//    (async reset).
//  - Latency: ALU results 0 cycles, registered by the RF at the next clk; loads/stores 0 cycles
//    plus wait cycles.
// CONFIGURATION
//  WB_COUNTERS_EN defined:
//    - rdcycle increments every clk out of reset.
//    - rdinstret increments once per retired instruction; excepted instructions do not count.
//    - Both counters wrap at 2^64.
//  WB_COUNTERS_EN undefined: rdcycle and rdinstret are tied to 0 and no counter flops exist.
// TESTING
//  1. alu2reg, rd=5, result=0x1234 -> rf_we=1, waddr=5, wdata=0x1234 same cycle.
//     Same with rd=0 -> rf_we=0.
//  2. LB raddr=3, rdata=0x80FF_0000 -> rf_wdata=0xFFFF_FF80. LHU raddr=2 -> 0x0000_80FF.
//     LW raddr=0 -> 0x80FF_0000.
//  3. Load with dmem_rvalid low for 3 cycles -> wb_stall=1 for 3 cycles. Write on the 4th cycle
//     with captured rd; upstream input changes during the stall are ignored.
//  4. Store addr=0x100, strb=4'b1100, dmem_wvalid low for 2 cycles -> dmem_wready held 3 cycles
//     with stable addr/data/strb; wb_stall=1 for 2 cycles.
//  5. LW raddr=2 -> wb_exception pulse, rf_we=0, rdinstret unchanged.
//     Reset asserted in ST_WAIT -> dmem_wready=0 immediately, state IDLE.
//  6. With WB_COUNTERS_EN: 10 ALU ops plus 1 load with 2 waits -> rdinstret=11, rdcycle counts every clk.
//     Without it: both counters 0.

Source files
------------

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- writeback stage of the three-stage RV32I pipeline.
//
// Sits directly downstream of execute. Takes execute's wb_* bundle and:
//   * drives the register-file write port in the same cycle (ALU results and
//     loads whose data is already valid),
//   * issues data-memory stores (dmem_wready + addr/data/strb),
//   * aligns and sign/zero-extends load data,
//   * stalls upstream while a load or store handshake is outstanding,
//   * pulses wb_exception on a misaligned or illegal access.
//
// Optional feature: define WB_COUNTERS_EN to build the 64-bit rdcycle and
// rdinstret counters. When it is undefined, both outputs are tied to 0 and no
// counter flops exist.
//
// Ports
//   clk, resetb                 clock (rising edge), async active-low reset
//   wb_valid                    execute presents a valid instruction
//   wb_result                   ALU/link/LUI/AUIPC result
//   wb_alu2reg/mem2reg/memwr    write result / load / store
//   wb_dst_sel                  rd index
//   wb_raddr, wb_aluop          load byte offset and load funct3
//   wb_waddr/wstrb/wdata        store request, pre-shifted by execute
//   dmem_rdata, dmem_rvalid     word-aligned load data and its valid
//   dmem_wvalid                 store accepted by memory
//   dmem_wready/waddr/wdata/wstrb  store request to memory
//   rf_we/waddr/wdata           register-file write port (also forwarding)
//   wb_stall                    hold execute/IF_ID this cycle
//   wb_exception                one-cycle pulse on an illegal access
//   rdcycle, rdinstret          cycle / retired-instruction counters
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int XLEN     = 32,
  parameter int REGSEL_W = 5
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  wb_valid,
  input  logic [XLEN-1:0]       wb_result,
  input  logic                  wb_alu2reg,
  input  logic                  wb_mem2reg,
  input  logic                  wb_memwr,
  input  logic [REGSEL_W-1:0]   wb_dst_sel,
  input  logic [1:0]            wb_raddr,
  input  logic [2:0]            wb_aluop,
  input  logic [XLEN-1:0]       wb_waddr,
  input  logic [XLEN/8-1:0]     wb_wstrb,
  input  logic [XLEN-1:0]       wb_wdata,
  input  logic [XLEN-1:0]       dmem_rdata,
  input  logic                  dmem_rvalid,
  input  logic                  dmem_wvalid,
  output logic                  dmem_wready,
  output logic [XLEN-1:0]       dmem_waddr,
  output logic [XLEN-1:0]       dmem_wdata,
  output logic [XLEN/8-1:0]     dmem_wstrb,
  output logic                  rf_we,
  output logic [REGSEL_W-1:0]   rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  wb_stall,
  output logic                  wb_exception,
  output logic [63:0]           rdcycle,
  output logic [63:0]           rdinstret
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Select the addressed byte/half of the word and extend it per funct3.
  function automatic logic [XLEN-1:0] load_align(input logic [2:0]      f3,
                                                 input logic [1:0]      off,
                                                 input logic [XLEN-1:0] w);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    r = {{(XLEN-8){b[7]}}, b};
      3'd1:    r = {{(XLEN-16){h[15]}}, h};
      3'd4:    r = {{(XLEN-8){1'b0}}, b};
      3'd5:    r = {{(XLEN-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Loads that are misaligned for their size or use an undefined funct3.
  function automatic logic load_illegal(input logic [2:0] f3,
                                        input logic [1:0] off);
    logic bad;
    case (f3)
      3'd0, 3'd4: bad = 1'b0;
      3'd1, 3'd5: bad = off[0];
      3'd2:       bad = (off != 2'd0);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

  state_t                state_q, state_d;
  logic [REGSEL_W-1:0]   ld_rd_q, ld_rd_d;
  logic [2:0]            ld_f3_q, ld_f3_d;
  logic [1:0]            ld_off_q, ld_off_d;
  logic [XLEN-1:0]       st_addr_q, st_addr_d;
  logic [XLEN-1:0]       st_data_q, st_data_d;
  logic [XLEN/8-1:0]     st_strb_q, st_strb_d;

  logic                  idle_illegal;
  logic                  rf_we_c;
  logic [REGSEL_W-1:0]   rf_waddr_c;
  logic [XLEN-1:0]       rf_wdata_c;
  logic                  wready_c;
  logic [XLEN-1:0]       waddr_c;
  logic [XLEN-1:0]       wdata_c;
  logic [XLEN/8-1:0]     wstrb_c;
  logic                  stall_c;
  logic                  exc_c;

  // A load and a store flagged together is malformed, as is a bad load.
  assign idle_illegal = wb_mem2reg &
                        (wb_memwr | load_illegal(wb_aluop, wb_raddr));

  always_comb begin
    state_d    = state_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_off_d   = ld_off_q;
    st_addr_d  = st_addr_q;
    st_data_d  = st_data_q;
    st_strb_d  = st_strb_q;
    rf_we_c    = 1'b0;
    rf_waddr_c = wb_dst_sel;
    rf_wdata_c = wb_result;
    wready_c   = 1'b0;
    waddr_c    = wb_waddr;
    wdata_c    = wb_wdata;
    wstrb_c    = wb_wstrb;
    stall_c    = 1'b0;
    exc_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (wb_valid) begin
          if (idle_illegal) begin
            exc_c = 1'b1;
          end else if (wb_mem2reg) begin
            // mem2reg takes precedence over alu2reg.
            rf_wdata_c = load_align(wb_aluop, wb_raddr, dmem_rdata);
            if (dmem_rvalid) begin
              rf_we_c = (wb_dst_sel != '0);
            end else begin
              ld_rd_d  = wb_dst_sel;
              ld_f3_d  = wb_aluop;
              ld_off_d = wb_raddr;
              state_d  = LD_WAIT;
              stall_c  = 1'b1;
            end
          end else if (wb_memwr) begin
            wready_c = 1'b1;
            if (!dmem_wvalid) begin
              st_addr_d = wb_waddr;
              st_data_d = wb_wdata;
              st_strb_d = wb_wstrb;
              state_d   = ST_WAIT;
              stall_c   = 1'b1;
            end
          end else begin
            rf_we_c = wb_alu2reg && (wb_dst_sel != '0);
          end
        end
      end

      LD_WAIT: begin
        // Upstream inputs are ignored; everything comes from the capture.
        rf_waddr_c = ld_rd_q;
        rf_wdata_c = load_align(ld_f3_q, ld_off_q, dmem_rdata);
        if (dmem_rvalid) begin
          rf_we_c = (ld_rd_q != '0);
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end

      ST_WAIT: begin
        // Hold the captured request stable until memory accepts it.
        wready_c = 1'b1;
        waddr_c  = st_addr_q;
        wdata_c  = st_data_q;
        wstrb_c  = st_strb_q;
        if (dmem_wvalid) begin
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= IDLE;
      ld_rd_q   <= '0;
      ld_f3_q   <= '0;
      ld_off_q  <= '0;
      st_addr_q <= '0;
      st_data_q <= '0;
      st_strb_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_rd_q   <= ld_rd_d;
      ld_f3_q   <= ld_f3_d;
      ld_off_q  <= ld_off_d;
      st_addr_q <= st_addr_d;
      st_data_q <= st_data_d;
      st_strb_q <= st_strb_d;
    end
  end

  // Enables are qualified with resetb so they drop the instant reset asserts,
  // even while execute is still presenting an instruction.
  assign rf_we        = rf_we_c  & resetb;
  assign rf_waddr     = rf_waddr_c;
  assign rf_wdata     = rf_wdata_c;
  assign dmem_wready  = wready_c & resetb;
  assign dmem_waddr   = waddr_c;
  assign dmem_wdata   = wdata_c;
  assign dmem_wstrb   = wstrb_c;
  assign wb_stall     = stall_c  & resetb;
  assign wb_exception = exc_c    & resetb;

`ifdef WB_COUNTERS_EN
  logic        retire;
  logic [63:0] cycle_q, cycle_d;
  logic [63:0] instret_q, instret_d;

  // An instruction retires when it completes without exception: immediately
  // in IDLE, or on the handshake that ends a wait state.
  assign retire = ((state_q == IDLE) && wb_valid && !idle_illegal &&
                   (wb_mem2reg ? dmem_rvalid :
                    wb_memwr   ? dmem_wvalid : 1'b1)) ||
                  ((state_q == LD_WAIT) && dmem_rvalid) ||
                  ((state_q == ST_WAIT) && dmem_wvalid);

  assign cycle_d   = cycle_q + 64'd1;
  assign instret_d = retire ? instret_q + 64'd1 : instret_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign rdcycle   = cycle_q;
  assign rdinstret = instret_q;
`else
  assign rdcycle   = '0;
  assign rdinstret = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk;
  logic        resetb;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic        wb_alu2reg;
  logic        wb_mem2reg;
  logic        wb_memwr;
  logic [4:0]  wb_dst_sel;
  logic [1:0]  wb_raddr;
  logic [2:0]  wb_aluop;
  logic [31:0] wb_waddr;
  logic [3:0]  wb_wstrb;
  logic [31:0] wb_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic        dmem_wvalid;
  logic        dmem_wready;
  logic [31:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_stall;
  logic        wb_exception;
  logic [63:0] rdcycle;
  logic [63:0] rdinstret;

  int n_cmp = 0;
  int n_bad = 0;

  wb_stage dut (
    .clk(clk), .resetb(resetb), .wb_valid(wb_valid), .wb_result(wb_result),
    .wb_alu2reg(wb_alu2reg), .wb_mem2reg(wb_mem2reg), .wb_memwr(wb_memwr),
    .wb_dst_sel(wb_dst_sel), .wb_raddr(wb_raddr), .wb_aluop(wb_aluop),
    .wb_waddr(wb_waddr), .wb_wstrb(wb_wstrb), .wb_wdata(wb_wdata),
    .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid), .dmem_wvalid(dmem_wvalid),
    .dmem_wready(dmem_wready), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_stall(wb_stall), .wb_exception(wb_exception),
    .rdcycle(rdcycle), .rdinstret(rdinstret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Load result: shift the addressed unit down, mask to size, extend by value.
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] w);
    logic [31:0] r;
    case (f3)
      3'd0, 3'd4: begin
        r = (w >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && r >= 32'h80) r = r - 32'h100;
      end
      3'd1, 3'd5: begin
        r = (w >> (16 * off[1])) & 32'hFFFF;
        if (f3 == 3'd1 && r >= 32'h8000) r = r - 32'h10000;
      end
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic m_illegal(input logic mem, input logic wr,
                                     input logic [2:0] f3, input logic [1:0] off);
    int size;
    if (!mem) return 1'b0;
    if (wr) return 1'b1;
    if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
    size = 1 << (int'(f3) % 4);
    return (int'(off) % size) != 0;
  endfunction

  logic        m_ld, m_st;
  logic [4:0]  m_ld_rd;
  logic [2:0]  m_ld_f3;
  logic [1:0]  m_ld_off;
  logic [31:0] m_st_a, m_st_d;
  logic [3:0]  m_st_s;
  logic [63:0] m_cycle, m_instret;

  initial begin
    m_ld = 1'b0; m_st = 1'b0; m_ld_rd = '0; m_ld_f3 = '0; m_ld_off = '0;
    m_st_a = '0; m_st_d = '0; m_st_s = '0; m_cycle = '0; m_instret = '0;
  end

  always @(negedge clk) begin
    logic        e_we, e_wr, e_st, e_ex, ret;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_sa, e_sd;
    logic [3:0]  e_ss;
    if (!resetb) begin
      m_ld = 1'b0; m_st = 1'b0; m_cycle = '0; m_instret = '0;
      chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
      chk("rst_wready", {63'd0, dmem_wready}, 64'd0);
      chk("rst_stall", {63'd0, wb_stall}, 64'd0);
      chk("rst_exc", {63'd0, wb_exception}, 64'd0);
      chk("rst_rdcycle", rdcycle, 64'd0);
      chk("rst_rdinstret", rdinstret, 64'd0);
    end else begin
      e_we = 0; e_wr = 0; e_st = 0; e_ex = 0; ret = 0;
      e_wa = '0; e_wd = '0; e_sa = '0; e_sd = '0; e_ss = '0;
      if (m_ld) begin
        if (dmem_rvalid) begin
          e_we = (m_ld_rd != 0); e_wa = m_ld_rd;
          e_wd = m_load(m_ld_f3, m_ld_off, dmem_rdata);
          ret = 1; m_ld = 0;
        end else e_st = 1;
      end else if (m_st) begin
        e_wr = 1; e_sa = m_st_a; e_sd = m_st_d; e_ss = m_st_s;
        if (dmem_wvalid) begin ret = 1; m_st = 0; end else e_st = 1;
      end else if (wb_valid) begin
        if (m_illegal(wb_mem2reg, wb_memwr, wb_aluop, wb_raddr)) begin
          e_ex = 1;
        end else if (wb_mem2reg) begin
          if (dmem_rvalid) begin
            e_we = (wb_dst_sel != 0); e_wa = wb_dst_sel;
            e_wd = m_load(wb_aluop, wb_raddr, dmem_rdata);
            ret = 1;
          end else begin
            m_ld = 1; m_ld_rd = wb_dst_sel; m_ld_f3 = wb_aluop; m_ld_off = wb_raddr;
            e_st = 1;
          end
        end else if (wb_memwr) begin
          e_wr = 1; e_sa = wb_waddr; e_sd = wb_wdata; e_ss = wb_wstrb;
          if (dmem_wvalid) ret = 1;
          else begin
            m_st = 1; m_st_a = wb_waddr; m_st_d = wb_wdata; m_st_s = wb_wstrb;
            e_st = 1;
          end
        end else begin
          e_we = wb_alu2reg && (wb_dst_sel != 0); e_wa = wb_dst_sel; e_wd = wb_result;
          ret = 1;
        end
      end
      chk("rf_we", {63'd0, rf_we}, {63'd0, e_we});
      if (e_we) begin
        chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, e_wa});
        chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, e_wd});
      end
      chk("dmem_wready", {63'd0, dmem_wready}, {63'd0, e_wr});
      if (e_wr) begin
        chk("dmem_waddr", {32'd0, dmem_waddr}, {32'd0, e_sa});
        chk("dmem_wdata", {32'd0, dmem_wdata}, {32'd0, e_sd});
        chk("dmem_wstrb", {60'd0, dmem_wstrb}, {60'd0, e_ss});
      end
      chk("wb_stall", {63'd0, wb_stall}, {63'd0, e_st});
      chk("wb_exception", {63'd0, wb_exception}, {63'd0, e_ex});
`ifdef WB_COUNTERS_EN
      chk("rdcycle", rdcycle, m_cycle);
      chk("rdinstret", rdinstret, m_instret);
`else
      chk("rdcycle", rdcycle, 64'd0);
      chk("rdinstret", rdinstret, 64'd0);
`endif
      m_cycle = m_cycle + 64'd1;
      if (ret) m_instret = m_instret + 64'd1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wb_valid = 0; wb_alu2reg = 0; wb_mem2reg = 0; wb_memwr = 0;
    dmem_rvalid = 0; dmem_wvalid = 0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] res);
    wb_valid = 1; wb_alu2reg = 1; wb_mem2reg = 0; wb_memwr = 0;
    wb_dst_sel = rd; wb_result = res;
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                      input logic [31:0] rdata, input logic rv);
    wb_valid = 1; wb_alu2reg = 0; wb_mem2reg = 1; wb_memwr = 0;
    wb_dst_sel = rd; wb_aluop = f3; wb_raddr = off; dmem_rdata = rdata; dmem_rvalid = rv;
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       input logic wv);
    wb_valid = 1; wb_alu2reg = 0; wb_mem2reg = 0; wb_memwr = 1;
    wb_waddr = a; wb_wstrb = s; wb_wdata = d; dmem_wvalid = wv;
  endtask

  task automatic do_reset();
    resetb = 0;
    tick(); tick();
    tick();
    resetb = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetb = 1; wb_result = '0; wb_dst_sel = '0; wb_raddr = '0; wb_aluop = '0;
    wb_waddr = '0; wb_wstrb = '0; wb_wdata = '0; dmem_rdata = '0;
    idle_in();
    #2 resetb = 0;
    alu(5'd5, 32'h1234);
    tick();
    #2;
    chk("reset_rf_we", {63'd0, rf_we}, 64'd0);
    chk("reset_rdcycle", rdcycle, 64'd0);
    idle_in();
    tick();
    resetb = 1;

    // ALU writes
    tick(); alu(5'd5, 32'h1234); #2;
    chk("alu_we", {63'd0, rf_we}, 64'd1);
    chk("alu_waddr", {59'd0, rf_waddr}, 64'd5);
    chk("alu_wdata", {32'd0, rf_wdata}, 64'h1234);
    tick(); alu(5'd0, 32'h1234); #2;
    chk("alu_x0_we", {63'd0, rf_we}, 64'd0);

    // Load extraction
    tick(); load(5'd7, 3'd0, 2'd3, 32'h80FF_0000, 1'b1); #2;
    chk("lb_we", {63'd0, rf_we}, 64'd1);
    chk("lb_data", {32'd0, rf_wdata}, 64'hFFFF_FF80);
    tick(); load(5'd7, 3'd5, 2'd2, 32'h80FF_0000, 1'b1); #2;
    chk("lhu_data", {32'd0, rf_wdata}, 64'h0000_80FF);
    tick(); load(5'd7, 3'd2, 2'd0, 32'h80FF_0000, 1'b1); #2;
    chk("lw_data", {32'd0, rf_wdata}, 64'h80FF_0000);

    // Load with three stalled cycles; upstream changes are ignored
    tick(); load(5'd9, 3'd2, 2'd0, 32'h0, 1'b0); #2;
    chk("ldw_stall0", {63'd0, wb_stall}, 64'd1);
    chk("ldw_we0", {63'd0, rf_we}, 64'd0);
    tick(); alu(5'd3, 32'hDEAD); dmem_rvalid = 0; #2;
    chk("ldw_stall1", {63'd0, wb_stall}, 64'd1);
    tick(); #2;
    chk("ldw_stall2", {63'd0, wb_stall}, 64'd1);
    tick(); dmem_rdata = 32'h1234_5678; dmem_rvalid = 1; #2;
    chk("ldw_stall3", {63'd0, wb_stall}, 64'd0);
    chk("ldw_we", {63'd0, rf_we}, 64'd1);
    chk("ldw_waddr", {59'd0, rf_waddr}, 64'd9);
    chk("ldw_wdata", {32'd0, rf_wdata}, 64'h1234_5678);
    tick(); idle_in();

    // Store with two unaccepted cycles
    tick(); store(32'h100, 4'b1100, 32'hAABB_0000, 1'b0); #2;
    chk("st_wready0", {63'd0, dmem_wready}, 64'd1);
    chk("st_stall0", {63'd0, wb_stall}, 64'd1);
    tick(); store(32'h200, 4'b0011, 32'h0000_1111, 1'b0); #2;
    chk("st_wready1", {63'd0, dmem_wready}, 64'd1);
    chk("st_addr1", {32'd0, dmem_waddr}, 64'h100);
    chk("st_strb1", {60'd0, dmem_wstrb}, 64'hC);
    chk("st_data1", {32'd0, dmem_wdata}, 64'hAABB_0000);
    chk("st_stall1", {63'd0, wb_stall}, 64'd1);
    tick(); dmem_wvalid = 1; #2;
    chk("st_wready2", {63'd0, dmem_wready}, 64'd1);
    chk("st_addr2", {32'd0, dmem_waddr}, 64'h100);
    chk("st_stall2", {63'd0, wb_stall}, 64'd0);
    tick(); idle_in(); #2;
    chk("st_wready_done", {63'd0, dmem_wready}, 64'd0);

    // Misaligned LW
    tick(); load(5'd4, 3'd2, 2'd2, 32'hFFFF_FFFF, 1'b1); #2;
    chk("exc_pulse", {63'd0, wb_exception}, 64'd1);
    chk("exc_we", {63'd0, rf_we}, 64'd0);
    tick(); idle_in(); #2;
    chk("exc_clear", {63'd0, wb_exception}, 64'd0);

    // Reset while a store is pending
    tick(); store(32'h300, 4'b1111, 32'hCAFE_F00D, 1'b0);
    tick(); idle_in(); #2;
    chk("rst_st_wready_before", {63'd0, dmem_wready}, 64'd1);
    resetb = 0; #1;
    chk("rst_st_wready_async", {63'd0, dmem_wready}, 64'd0);
    chk("rst_st_stall_async", {63'd0, wb_stall}, 64'd0);
    tick(); tick();
    resetb = 1; alu(5'd6, 32'h55); #2;
    chk("rst_st_idle_we", {63'd0, rf_we}, 64'd1);
    chk("rst_st_idle_wready", {63'd0, dmem_wready}, 64'd0);

    // Counters: 10 ALU ops then one load with two waits
    tick(); idle_in();
    do_reset();
    alu(5'd1, 32'd0);
    for (int i = 1; i < 10; i++) begin
      tick(); alu(5'(i + 1), 32'(i));
    end
    tick(); load(5'd2, 3'd2, 2'd0, 32'h0, 1'b0);
    tick(); idle_in();
    tick(); dmem_rvalid = 1;
    tick(); idle_in(); #2;
`ifdef WB_COUNTERS_EN
    chk("cnt_instret", rdinstret, 64'd11);
    chk("cnt_cycle", rdcycle, 64'd13);
`else
    chk("cnt_instret_off", rdinstret, 64'd0);
    chk("cnt_cycle_off", rdcycle, 64'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      resetb      = ($urandom_range(0, 199) != 0);
      wb_valid    = ($urandom_range(0, 4) != 0);
      wb_alu2reg  = 1'($urandom_range(0, 1));
      wb_mem2reg  = ($urandom_range(0, 2) == 0);
      wb_memwr    = ($urandom_range(0, 3) == 0);
      wb_dst_sel  = 5'($urandom_range(0, 31));
      wb_result   = $urandom;
      wb_aluop    = 3'($urandom_range(0, 7));
      wb_raddr    = 2'($urandom_range(0, 3));
      wb_waddr    = $urandom;
      wb_wstrb    = 4'($urandom_range(0, 15));
      wb_wdata    = $urandom;
      dmem_rdata  = $urandom;
      dmem_rvalid = 1'($urandom_range(0, 1));
      dmem_wvalid = 1'($urandom_range(0, 1));
    end
    tick(); resetb = 1; idle_in();
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
